// File: rtl/bcd_countdown.sv
// Multi-digit BCD down-counter with prescaled tick qualification, pause/resume
// and a registered one-cycle completion pulse. Digit 0 sits in bits [3:0].
module bcd_countdown #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dec_in,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   preset_in,
    input  logic                  start,
    input  logic                  pause,
    output logic [4*DIGITS-1:0]   dec_out,
    output logic                  running,
    output logic                  zero,
    output logic                  done_pulse,
    output logic                  borrow_out
);

    localparam int W = 4 * DIGITS;
    localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;

    state_t         r_state;
    logic [7:0]     r_pre;
    logic [W-1:0]   r_cnt;
    logic           r_done_pulse;

    logic [W-1:0]       w_dec;
    logic [W-1:0]       w_clamp;
    logic [DIGITS-1:0]  w_lz;
    logic               w_dec_zero;

    // w_lz[g] is high when every digit below g is zero, i.e. digit g receives a borrow.
    assign w_lz[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        logic [3:0] w_d;
        logic [3:0] w_p;
        assign w_d = r_cnt[4*g +: 4];
        assign w_p = preset_in[4*g +: 4];
        if (g < DIGITS - 1) begin : g_chain
            assign w_lz[g+1] = w_lz[g] & (w_d == 4'd0);
        end
        assign w_dec[4*g +: 4]   = !w_lz[g] ? w_d : ((w_d == 4'd0) ? 4'd9 : w_d - 4'd1);
        assign w_clamp[4*g +: 4] = (w_p > 4'd9) ? 4'd9 : w_p;
    end

    assign w_dec_zero = (w_dec == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_pre        <= 8'd0;
            r_cnt        <= '0;
            r_done_pulse <= 1'b0;
        end else begin
            r_done_pulse <= 1'b0;
            if (load) begin
                r_cnt   <= w_clamp;
                r_pre   <= 8'd0;
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!pause && start) begin
                            if (r_cnt == '0) begin
                                r_state      <= S_DONE;
                                r_done_pulse <= 1'b1;
                            end else begin
                                r_state <= S_RUN;
                            end
                        end
                    end
                    S_RUN: begin
                        if (pause) begin
                            r_state <= S_PAUSED;
                        end else if (dec_in) begin
                            if (r_pre == PRE_LAST) begin
                                r_pre <= 8'd0;
                                r_cnt <= w_dec;
                                if (w_dec_zero) begin
                                    r_state      <= S_DONE;
                                    r_done_pulse <= 1'b1;
                                end
                            end else begin
                                r_pre <= r_pre + 8'd1;
                            end
                        end
                    end
                    S_PAUSED: begin
                        if (!pause && start) r_state <= S_RUN;
                    end
                    S_DONE: ;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign dec_out    = r_cnt;
    assign running    = (r_state == S_RUN);
    assign zero       = (r_cnt == '0);
    assign done_pulse = r_done_pulse;
    assign borrow_out = 1'b0;

endmodule

// File: doc/bcd_countdown.md
Name: bcd_countdown

Overview:
- Multi-digit BCD down-counter; the decrementing counterpart of the per-digit up-count chain feeding the seven-segment display driver.
- Loads a BCD preset and decrements it on qualified tick pulses, with a borrow chain across digits.
- Signals completion when the value reaches zero.
- Output bus drives the display digit multiplexer directly: digit 0 in bits [3:0].

Parameters:
DIGITS, 4, number of BCD digits (1..8); count width is 4*DIGITS.
PRESCALE, 1, number of accepted dec_in pulses per decrement (1..255).

Ports:
clk  input  1  system clock, all state on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset).
dec_in  input  1  tick pulse, sampled each clk; one-cycle pulses expected.
load  input  1  load preset_in, highest priority.
preset_in  input  4*DIGITS  BCD preset, digit 0 in bits [3:0].
start  input  1  start or resume counting.
pause  input  1  suspend counting.
dec_out  output  4*DIGITS  current BCD value (registered).
running  output  1  high while in RUN.
zero  output  1  high when dec_out == 0.
done_pulse  output  1  one-cycle pulse on entry to DONE.
borrow_out  output  1  one-cycle pulse when a decrement occurs at value 0 in the top digit chain. Never asserted in normal operation; reserved for cascading. Held 0.

Behaviour:
- Reset (reset=0, async), values:
  - dec_out = 0
  - state = IDLE
  - prescaler = 0
  - running = 0
  - done_pulse = 0
  - borrow_out = 0
  - zero = 1
- States are IDLE, RUN, PAUSED and DONE, encoded in 2 bits.
- Priority each cycle: load > pause > start > tick.
- load (any state):
  - dec_out <= preset_in, with each digit >9 clamped to 9.
  - prescaler <= 0.
  - state <= IDLE.
  - Ticks in the same cycle are discarded.
- IDLE:
  - start with loaded value nonzero goes to RUN next cycle.
  - start with value 0 goes to DONE and done_pulse asserts the next cycle.
  - dec_in is ignored.
- RUN:
  - A tick is a cycle with dec_in=1.
  - On a tick, if prescaler == PRESCALE-1, then prescaler <= 0 and a decrement is performed. Otherwise prescaler increments.
  - pause goes to PAUSED, and a tick in the same cycle is discarded.
- Decrement:
  - Digit 0 decrements.
  - Any digit at 0 becomes 9 and borrows into the next digit.
  - A digit decrements only when all lower digits were 0.
  - Examples: 1000 -> 0999, 0100 -> 0099.
- If a decrement results in all digits 0, state <= DONE in the same edge. done_pulse is high for exactly the next cycle after entry, i.e. registered, one cycle.
- PAUSED:
  - dec_out and prescaler are frozen.
  - start returns to RUN and the prescaler phase is preserved.
  - pause held with start: pause wins, stay PAUSED.
- DONE:
  - dec_out stays 0; start and dec_in are ignored.
  - Only load or reset exits.
- Output timing:
  - running is combinational from state (state==RUN).
  - zero is combinational from dec_out.
  - dec_out updates on the clk edge after the qualifying tick (latency 1).
- Reset asserted mid-count clears immediately (async); release is sampled on the next clk.
- Every digit of dec_out is always valid BCD (0..9).

Test Plan:
- Reset low mid-RUN with dec_out=0042 -> dec_out=0000, running=0, zero=1 immediately, without waiting for clk. After release, state is IDLE.
- Borrow chain: DIGITS=4, PRESCALE=1. Load 1000, start, then 1 dec_in pulse -> dec_out=0999. 999 more pulses -> 0000, done_pulse exactly one cycle, running=0.
- Prescale: PRESCALE=3. Load 0005, start, 7 pulses -> dec_out=0003 and prescaler phase 1. Pause, 5 pulses -> dec_out unchanged. Start, 2 pulses -> 0002.
- Edge cases:
  - load 00A9 -> dec_out=0099 (clamped).
  - load 0000 then start -> DONE with done_pulse, no decrement.
  - pulses in DONE -> dec_out stays 0000.
- Simultaneous events:
  - load=1, dec_in=1, start=1 in RUN -> preset loaded, state IDLE, no decrement.
  - pause=1, start=1 -> PAUSED.
